requant_stage: RTL

//  Pipelined requantizer between the conv/dense MAC array and the tanh_activation LUT stage.
//  Per beat: adds bias to a signed accumulator, multiplies by a fixed-point scale,

---
 rtl/requant_stage.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/requant_stage.sv
// requant_stage
//   Three-stage requantizer sitting between the MAC array and the tanh LUT.
//   Each beat is processed as ((acc + bias) * mult, round-shifted right by
//   shift) + zp, and the result is saturated to a signed dataWidth value.
//
//   Stage map:
//     S1  sum  = acc + bias                      (accWidth+1 bits, exact)
//     S2  prod = sum * mult                      (signed, exact)
//     S3  r    = (prod + half) >>> shift         (round half toward +inf)
//         v    = clamp(r + zp)                   (registered output)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   cfg_load_i   capture cfg_mult_i / cfg_shift_i / cfg_zp_i (only when idle)
//   cfg_mult_i   signed scale
//   cfg_shift_i  unsigned right-shift amount
//   cfg_zp_i     signed output zero point
//   in_valid_i   / in_ready_o / in_acc_i / in_bias_i / in_last_i : input beat
//   out_valid_o  / out_ready_i / out_data_o / out_last_o           : output beat
//   sat_count_o  clipped outputs since reset or the last honoured cfg_load
//   busy_o       any stage holds a valid beat
//
// Handshake: a beat moves across an interface on a rising edge where
//   valid & ready are both high. The whole pipeline advances together
//   (en = !out_valid | out_ready); in_ready is en itself, so a producer
//   seeing in_ready low must hold its beat. The output beat is held
//   unchanged while out_valid & !out_ready.

module requant_stage #(
  parameter int accWidth   = 32,
  parameter int dataWidth  = 8,
  parameter int multWidth  = 16,
  parameter int shiftWidth = 5,
  parameter int cntWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_load_i,
  input  logic [multWidth-1:0]  cfg_mult_i,
  input  logic [shiftWidth-1:0] cfg_shift_i,
  input  logic [dataWidth-1:0]  cfg_zp_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [accWidth-1:0]   in_acc_i,
  input  logic [accWidth-1:0]   in_bias_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [dataWidth-1:0]  out_data_o,
  output logic                  out_last_o,
  output logic [cntWidth-1:0]   sat_count_o,
  output logic                  busy_o
);

  // Widths chosen so no intermediate can overflow.
  localparam int SUM_W  = accWidth + 1;
  localparam int PROD_W = SUM_W + multWidth;
  localparam int RND_W  = PROD_W + 1;
  localparam int V_W    = RND_W + 1;

  localparam logic signed [V_W-1:0] V_MAX = V_W'(2 ** (dataWidth - 1) - 1);
  localparam logic signed [V_W-1:0] V_MIN = ~V_MAX;

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  logic signed [multWidth-1:0] mult_q;
  logic [shiftWidth-1:0]       shift_q;
  logic signed [dataWidth-1:0] zp_q;

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  logic                     s1_valid_q;
  logic signed [SUM_W-1:0]  s1_sum_q;
  logic                     s1_last_q;

  logic                     s2_valid_q;
  logic signed [PROD_W-1:0] s2_prod_q;
  logic                     s2_last_q;

  logic                     out_valid_q;
  logic [dataWidth-1:0]     out_data_q;
  logic                     out_last_q;
  logic [cntWidth-1:0]      sat_count_q;

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  logic en;
  logic busy;
  logic cfg_fire;

  assign en       = !out_valid_q || out_ready_i;
  assign busy     = s1_valid_q || s2_valid_q || out_valid_q;
  // Config only changes when nothing is in flight and nothing is being
  // offered, so every beat sees one consistent configuration.
  assign cfg_fire = cfg_load_i && !busy && !in_valid_i;

  // ---------------------------------------------------------------------
  // Datapath (next-state values)
  // ---------------------------------------------------------------------
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [RND_W-1:0]  rnd_term;
  logic signed [RND_W-1:0]  rounded;
  logic signed [V_W-1:0]    v_full;
  logic [dataWidth-1:0]     data_d;
  logic                     clip_d;

  // S1: sign-extend both operands by one bit so the sum is exact.
  assign sum_d = SUM_W'($signed(in_acc_i)) + SUM_W'($signed(in_bias_i));

  // S2: full-precision signed product.
  assign prod_d = PROD_W'(s1_sum_q) * PROD_W'(mult_q);

  // S3: round-half-up right shift, zero point add, saturation.
  always_comb begin
    rnd_term = '0;
    if (shift_q != '0) begin
      rnd_term = RND_W'(1) <<< (shift_q - shiftWidth'(1));
    end
    // Arithmetic shift: large shifts collapse negatives to -1, positives to 0.
    rounded = (RND_W'(s2_prod_q) + rnd_term) >>> shift_q;
    v_full  = V_W'(rounded) + V_W'(zp_q);

    data_d = v_full[dataWidth-1:0];
    clip_d = 1'b0;
    if (v_full > V_MAX) begin
      data_d = V_MAX[dataWidth-1:0];
      clip_d = 1'b1;
    end else if (v_full < V_MIN) begin
      data_d = V_MIN[dataWidth-1:0];
      clip_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mult_q      <= multWidth'(1);
      shift_q     <= '0;
      zp_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (cfg_fire) begin
        mult_q      <= $signed(cfg_mult_i);
        shift_q     <= cfg_shift_i;
        zp_q        <= $signed(cfg_zp_i);
        sat_count_q <= '0;
      end

      // Bubbles travel with the valid bits; payload registers only load
      // when a real beat arrives so stalled/empty slots keep their value.
      if (en) begin
        s1_valid_q  <= in_valid_i;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;

        if (in_valid_i) begin
          s1_sum_q  <= sum_d;
          s1_last_q <= in_last_i;
        end

        if (s1_valid_q) begin
          s2_prod_q <= prod_d;
          s2_last_q <= s1_last_q;
        end

        if (s2_valid_q) begin
          out_data_q <= data_d;
          out_last_q <= s2_last_q;
          // cfg_fire cannot coincide with this branch: it requires !busy.
          if (clip_d && (sat_count_q != '1)) begin
            sat_count_q <= sat_count_q + cntWidth'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign sat_count_o = sat_count_q;
  assign busy_o      = busy;

endmodule
